// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one builtin_fadd adder among NUM_REQ clients.
// One operation in flight; a watchdog aborts stuck operations and resets the adder.
module fpu_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_z,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   fadd_rst,
  output logic [31:0]            fadd_input_a,
  output logic                   fadd_input_a_stb,
  input  logic                   fadd_input_a_ack,
  output logic [31:0]            fadd_input_b,
  output logic                   fadd_input_b_stb,
  input  logic                   fadd_input_b_ack,
  input  logic [31:0]            fadd_output_z,
  input  logic                   fadd_output_z_stb,
  output logic                   fadd_output_z_ack
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [IDW:0]   NREQ_EXT = (IDW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_RESET_FADD, S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESP
  } state_t;

  state_t           state_q;
  logic [RCW-1:0]   rst_cnt_q;
  logic [WDW-1:0]   wd_cnt_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic [31:0]      z_q;
  logic             err_q;

  logic [31:0]      a_slice [NUM_REQ];
  logic [31:0]      b_slice [NUM_REQ];
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     scan_sum;
  logic             hs_done;
  logic             wd_expired;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_slice[i] = req_a[32*i +: 32];
    assign b_slice[i] = req_b[32*i +: 32];
  end

  // Scan ptr+1, ptr+2, ... so the last-served requester has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= NREQ_EXT) scan_sum = scan_sum - NREQ_EXT;
      if (!grant_found && req_valid[scan_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    hs_done = 1'b0;
    case (state_q)
      S_SEND_A: hs_done = fadd_input_a_ack;
      S_SEND_B: hs_done = fadd_input_b_ack;
      S_WAIT_Z: hs_done = fadd_output_z_stb;
      default:  hs_done = 1'b0;
    endcase
  end

  // A handshake completing on the last watchdog cycle takes precedence.
  assign wd_expired = (wd_cnt_q >= WD_LAST) && !hs_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_FADD;
      rst_cnt_q <= '0;
      wd_cnt_q  <= '0;
      ptr_q     <= IDW'(NUM_REQ - 1);
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      z_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_RESET_FADD: begin
          if (rst_cnt_q == RC_LAST) state_q <= S_IDLE;
          else rst_cnt_q <= rst_cnt_q + RCW'(1);
        end
        S_IDLE: begin
          if (grant_found) begin
            op_a_q   <= a_slice[grant_idx];
            op_b_q   <= b_slice[grant_idx];
            id_q     <= grant_idx;
            wd_cnt_q <= '0;
            state_q  <= S_SEND_A;
          end
        end
        S_SEND_A, S_SEND_B, S_WAIT_Z: begin
          wd_cnt_q <= wd_cnt_q + WDW'(1);
          if (hs_done) begin
            if (state_q == S_SEND_A) state_q <= S_SEND_B;
            else if (state_q == S_SEND_B) state_q <= S_WAIT_Z;
            else begin
              z_q     <= fadd_output_z;
              err_q   <= 1'b0;
              state_q <= S_RESP;
            end
          end else if (wd_expired) begin
            z_q     <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ptr_q <= id_q;
          if (err_q) begin
            rst_cnt_q <= '0;
            state_q   <= S_RESET_FADD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_RESET_FADD;
      endcase
    end
  end

  // Client side: req_ready[g] pulses in the IDLE cycle whose clock edge commits
  // requester g's operands; req_valid/req_a/req_b must stay stable up to that edge.
  assign req_ready  = (state_q == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign resp_z     = (state_q == S_RESP) ? z_q : '0;
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign busy       = (state_q != S_IDLE);
  assign fadd_rst   = (state_q == S_RESET_FADD);

  assign fadd_input_a      = (state_q == S_SEND_A) ? op_a_q : '0;
  assign fadd_input_a_stb  = (state_q == S_SEND_A);
  assign fadd_input_b      = (state_q == S_SEND_B) ? op_b_q : '0;
  assign fadd_input_b_stb  = (state_q == S_SEND_B);
  assign fadd_output_z_ack = (state_q == S_WAIT_Z) && fadd_output_z_stb;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: a behavioural adder with programmable ack
// stall and result delay, a vector table of operations, and hand-written corner cases.
module tb_fpu_add_arbiter;
  localparam int NUM_REQ = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready, resp_valid;
  logic [31:0]           resp_z;
  logic                  resp_err, busy, fadd_rst;
  logic [31:0]           fadd_input_a, fadd_input_b, fadd_output_z;
  logic                  fadd_input_a_stb, fadd_input_a_ack;
  logic                  fadd_input_b_stb, fadd_input_b_ack;
  logic                  fadd_output_z_stb, fadd_output_z_ack;

  fpu_add_arbiter #(.NUM_REQ(4), .RST_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z),
    .resp_err(resp_err), .busy(busy), .fadd_rst(fadd_rst),
    .fadd_input_a(fadd_input_a), .fadd_input_a_stb(fadd_input_a_stb),
    .fadd_input_a_ack(fadd_input_a_ack),
    .fadd_input_b(fadd_input_b), .fadd_input_b_stb(fadd_input_b_stb),
    .fadd_input_b_ack(fadd_input_b_ack),
    .fadd_output_z(fadd_output_z), .fadd_output_z_stb(fadd_output_z_stb),
    .fadd_output_z_ack(fadd_output_z_ack)
  );

  int n_total = 0;
  int n_pass  = 0;

  // adder model configuration (written by the test sequence)
  int          a_stall = 0;
  int          z_delay = 0;
  bit          z_never = 1'b0;
  logic [31:0] z_val   = '0;

  // adder model: responds just after each rising edge
  initial begin
    int a_cnt, b_cnt, z_cnt;
    bit armed, b_hs_prev, z_prev;
    a_cnt = 0; b_cnt = 0; z_cnt = 0;
    armed = 0; b_hs_prev = 0; z_prev = 0;
    fadd_input_a_ack = 0; fadd_input_b_ack = 0;
    fadd_output_z_stb = 0; fadd_output_z = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
        armed = 0; b_hs_prev = 0; z_prev = 0;
        fadd_input_a_ack = 0; fadd_input_b_ack = 0; fadd_output_z_stb = 0;
      end else begin
        if (b_hs_prev) begin armed = 1; z_cnt = 0; end
        if (z_prev || (|resp_valid)) armed = 0;
        if (fadd_input_a_stb) begin
          fadd_input_a_ack = (a_cnt >= a_stall); a_cnt++;
        end else begin
          fadd_input_a_ack = 0; a_cnt = 0;
        end
        if (fadd_input_b_stb) begin
          fadd_input_b_ack = 1'b1; b_cnt++;
        end else begin
          fadd_input_b_ack = 0; b_cnt = 0;
        end
        if (armed) begin
          fadd_output_z_stb = !z_never && (z_cnt >= z_delay); z_cnt++;
        end else begin
          fadd_output_z_stb = 0;
        end
      end
      fadd_output_z = fadd_output_z_stb ? z_val : '0;
      b_hs_prev = fadd_input_b_stb && fadd_input_b_ack;
      z_prev = fadd_output_z_stb;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sampled from the first post-reset cycle: adder reset must last exactly 2 cycles.
  task automatic count_reset_window(input string tag);
    int hi = 0;
    int early = 0;
    int n = 0;
    step();
    while (fadd_rst && n < 10) begin
      hi++;
      if (req_ready != 0 || resp_valid != 0) early++;
      step(); n++;
    end
    check({tag, " fadd_rst cycles"}, hi, 2);
    check({tag, " quiet in reset"}, early, 0);
    check({tag, " busy after reset"}, {31'b0, busy}, 0);
  endtask

  // Drives one request, waits for the grant and the response, checks everything seen.
  task automatic run_op(input string tag, input logic [3:0] rv, input int g,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                        input int zd, input int as, input bit hold,
                        input logic exp_err, input int exp_lat);
    int n = 0;
    int t = 0;
    int a_hi = 0, a_bad = 0, b_early = 0, extra_rdy = 0;
    bit a_done = 0;
    logic [31:0] b_obs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = (i == g) ? a : (32'hA5A5_0000 | 32'(i));
      req_b[32*i +: 32] = (i == g) ? b : (32'h5A5A_0000 | 32'(i));
    end
    z_val = z; z_delay = zd; a_stall = as;
    req_valid = rv;
    #1;
    while (req_ready == 0 && n < 40) begin step(); n++; end
    check({tag, " grant"}, {28'b0, req_ready}, 32'(1) << g);
    while (resp_valid == 0 && t < 120) begin
      step(); t++;
      if (t == 1 && !hold) req_valid = '0;
      if (fadd_input_a_stb) begin
        a_hi++;
        if (fadd_input_a !== a) a_bad++;
      end else if (a_hi > 0) a_done = 1;
      if (fadd_input_b_stb) begin
        if (!a_done) b_early++;
        b_obs = fadd_input_b;
      end
      if (req_ready != 0) extra_rdy++;
    end
    check({tag, " resp_valid"}, {28'b0, resp_valid}, 32'(1) << g);
    check({tag, " resp_z"}, resp_z, exp_err ? 32'h0 : z);
    check({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    check({tag, " latency"}, t, exp_lat);
    check({tag, " a_stb cycles"}, a_hi, as + 1);
    check({tag, " a stable"}, a_bad, 0);
    check({tag, " b before a done"}, b_early, 0);
    check({tag, " operand b"}, b_obs, b);
    check({tag, " ready pulse"}, extra_rdy, 0);
  endtask

  typedef struct {
    logic [3:0]  valid;
    int          grant;
    logic [31:0] a, b, z;
    int          zd, as, lat;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int seen;
    // 1.0+2.0=3.0, 1.5+2.5=4.0, 0.5+0.25=0.75, -1+1=0, 10+(-4)=6, 3+1=4, 1+1=2
    tbl[0] = '{4'b0001, 0, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 0, 7};
    tbl[1] = '{4'b0110, 1, 32'h3FC00000, 32'h40200000, 32'h40800000, 0, 0, 4};
    tbl[2] = '{4'b0011, 0, 32'h3F000000, 32'h3E800000, 32'h3F400000, 1, 5, 10};
    tbl[3] = '{4'b1001, 3, 32'hBF800000, 32'h3F800000, 32'h00000000, 2, 0, 6};
    tbl[4] = '{4'b1000, 3, 32'h41200000, 32'hC0800000, 32'h40C00000, 0, 0, 4};
    tbl[5] = '{4'b1100, 2, 32'h40400000, 32'h3F800000, 32'h40800000, 0, 0, 4};
    tbl[6] = '{4'b1010, 3, 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 4};

    req_valid = 4'hF; req_a = '0; req_b = '0;

    // post-reset behaviour, requests pending the whole time
    step();
    check("in reset fadd_rst", {31'b0, fadd_rst}, 1);
    check("in reset busy", {31'b0, busy}, 1);
    check("in reset req_ready", {28'b0, req_ready}, 0);
    check("in reset a_stb", {31'b0, fadd_input_a_stb}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    count_reset_window("startup");
    check("first grant is req0", {28'b0, req_ready}, 32'h1);
    req_valid = '0;
    #1;
    check("withdraw drops ready", {28'b0, req_ready}, 0);
    step();
    check("withdraw no effect", {31'b0, busy}, 0);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].valid, tbl[i].grant, tbl[i].a, tbl[i].b,
             tbl[i].z, tbl[i].zd, tbl[i].as, 1'b0, 1'b0, tbl[i].lat);

    // round-robin with every requester held
    for (int k = 0; k < 5; k++)
      run_op($sformatf("rr%0d", k), 4'hF, k % 4, 32'h3F800000, 32'h40000000,
             32'h40400000, 0, 0, 1'b1, 1'b0, 4);
    req_valid = '0;

    // watchdog abort: result never arrives
    z_never = 1'b1;
    run_op("timeout", 4'b0100, 2, 32'h3F800000, 32'h40000000, 32'h40400000,
           0, 0, 1'b0, 1'b1, 65);
    z_never = 1'b0;
    count_reset_window("after timeout");
    run_op("post-timeout", 4'hF, 3, 32'h40000000, 32'h40000000, 32'h40800000,
           0, 0, 1'b0, 1'b0, 4);

    // reset while waiting for the result
    step();
    z_delay = 20; z_val = 32'h40400000;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    #1;
    check("midrst grant", {28'b0, req_ready}, 32'h1);
    repeat (4) step();
    req_valid = '0;
    check("midrst in wait_z", {30'b0, busy, fadd_input_b_stb}, 32'h2);
    rst = 1'b1;
    #1;
    check("midrst fadd_rst", {31'b0, fadd_rst}, 1);
    check("midrst busy", {31'b0, busy}, 1);
    check("midrst outputs", {18'b0, req_ready, resp_valid, resp_err, fadd_input_a_stb,
                             fadd_input_b_stb, fadd_output_z_ack, 2'b0}, 0);
    check("midrst resp_z", resp_z, 0);
    check("midrst operands", fadd_input_a | fadd_input_b, 0);
    seen = 0;
    repeat (3) begin
      step();
      if (resp_valid != 0) seen++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    count_reset_window("after midrst");
    check("midrst no resp", seen, 0);
    run_op("post-midrst", 4'b0011, 0, 32'h3F800000, 32'h3F800000, 32'h40000000,
           0, 0, 1'b0, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
